// File: rtl/spi_pkg.sv
// Shared types for the SPI slave core: FSM states, mode encoding and width default.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  // Mode number as {cpol, cpha}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

endpackage

// File: rtl/spi_slave_core_if.sv
// Serial link between the SPI master and the slave core (frame select, clock, data both ways).
interface spi_slave_core_if;
  logic sel;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output sel, output sclk, output mosi, input miso);
  modport slave  (input sel, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_edge_sync.sv
// Brings sclk/mosi/sel into the clk domain and keeps the previous sclk and sel levels for edge detection.
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic mosi,
  input  logic sel,
  input  logic prev_set,
  input  logic prev_val,
  output logic sclk_s,
  output logic mosi_s,
  output logic sel_s,
  output logic sclk_prev,
  output logic sel_rise
);

  logic sel_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sclk_s = sclk;
      assign mosi_s = mosi;
      assign sel_s  = sel;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sclk_q, mosi_q, sel_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sclk_q <= '0;
          mosi_q <= '0;
          sel_q  <= '0;
        end else begin
          sclk_q[0] <= sclk;
          mosi_q[0] <= mosi;
          sel_q[0]  <= sel;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sclk_q[i] <= sclk_q[i-1];
            mosi_q[i] <= mosi_q[i-1];
            sel_q[i]  <= sel_q[i-1];
          end
        end
      end

      assign sclk_s = sclk_q[SYNC_STAGES-1];
      assign mosi_s = mosi_q[SYNC_STAGES-1];
      assign sel_s  = sel_q[SYNC_STAGES-1];
    end
  endgenerate

  // prev_set forces the reference level to the idle polarity at frame start,
  // so an sclk already away from idle at select does not look like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_prev <= 1'b0;
      sel_d     <= 1'b0;
    end else begin
      sclk_prev <= prev_set ? prev_val : sclk_s;
      sel_d     <= sel_s;
    end
  end

  assign sel_rise = sel_s & ~sel_d;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave endpoint: LSB-first shift in/out in all four CPOL/CPHA modes, oversampled in the clk domain.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  spi_slave_core_if.slave   link,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_ovr
);

  localparam int unsigned      CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  state_t            state, state_n;
  spi_mode_t         mode_l;
  logic              cpol_l, cpha_l;
  logic              sclk_s, mosi_s, sel_s, sclk_prev, sel_rise;
  logic              toggled, lead, trail, sample_ev, drive_ev;
  logic              start, do_reload, do_sample, do_drive, to_idle, rxv_n, ferr_n;
  logic [DATA_W-1:0] shift_tx, rx_sh, pend_reg, reload_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              pending, miso_r;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (link.sclk),
    .mosi      (link.mosi),
    .sel       (link.sel),
    .prev_set  (start),
    .prev_val  (cpol),
    .sclk_s    (sclk_s),
    .mosi_s    (mosi_s),
    .sel_s     (sel_s),
    .sclk_prev (sclk_prev),
    .sel_rise  (sel_rise)
  );

  assign cpol_l      = (mode_l == MODE2) || (mode_l == MODE3);
  assign cpha_l      = (mode_l == MODE1) || (mode_l == MODE3);
  assign toggled     = (sclk_s != sclk_prev);
  assign lead        = toggled && (sclk_prev == cpol_l);
  assign trail       = toggled && (sclk_prev != cpol_l);
  assign sample_ev   = cpha_l ? trail : lead;
  assign drive_ev    = cpha_l ? lead : trail;
  assign reload_word = pending ? pend_reg : IDLE_TX;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    do_reload = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;
    to_idle   = 1'b0;
    rxv_n     = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: if (sel_rise) begin
        start   = 1'b1;
        state_n = LOAD;
      end
      LOAD: begin
        do_reload = 1'b1;
        state_n   = SHIFT;
      end
      SHIFT: begin
        // Deselect is checked first so it beats a coincident final sample.
        if (!sel_s) begin
          ferr_n  = (bit_cnt != '0);
          to_idle = 1'b1;
          state_n = IDLE;
        end else if (sample_ev) begin
          do_sample = 1'b1;
          if (bit_cnt == LAST) state_n = DONE;
        end else if (drive_ev) begin
          do_drive = 1'b1;
        end
      end
      DONE: begin
        do_reload = 1'b1;
        rxv_n     = 1'b1;
        if (sel_s) state_n = SHIFT;
        else begin
          to_idle = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_l    <= MODE0;
      shift_tx  <= '0;
      rx_sh     <= '0;
      rx_data   <= '0;
      bit_cnt   <= '0;
      miso_r    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      pend_reg  <= '0;
      pending   <= 1'b0;
      tx_ovr    <= 1'b0;
    end else begin
      rx_valid  <= rxv_n;
      frame_err <= ferr_n;
      if (start) mode_l <= spi_mode_t'({cpol, cpha});
      if (do_reload) begin
        shift_tx <= reload_word;
        bit_cnt  <= '0;
        if (!cpha_l && (state_n == SHIFT)) miso_r <= reload_word[0];
      end
      if (do_sample) begin
        rx_sh[bit_cnt] <= mosi_s;
        bit_cnt        <= bit_cnt + 1'b1;
      end
      if (do_drive) miso_r <= shift_tx[bit_cnt];
      if (state == DONE) rx_data <= rx_sh;
      if (to_idle) begin
        miso_r  <= 1'b0;
        bit_cnt <= '0;
      end
      // A load coinciding with a consume refills the register rather than overrunning it.
      if (tx_load) begin
        pend_reg <= tx_data;
        pending  <= 1'b1;
        if (pending && !do_reload) tx_ovr <= 1'b1;
      end else if (do_reload) begin
        pending <= 1'b0;
      end
    end
  end

  assign link.miso = miso_r;
  assign busy      = (state != IDLE);

endmodule
